// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt sequencer: divides Clk_xi into a Tick and turns selected Ticks
// into single-cycle CPU step enables (Cpu_En) based on run switch, step button and halt.
module cpu_clk_ctrl #(
  parameter int unsigned TICK_N = 500000,
  parameter int unsigned DB_CNT = 4
) (
  input  logic        Clk_xi,
  input  logic        Rst_xi,
  input  logic        Run_Sw,
  input  logic        Step_Btn,
  input  logic        Halt_Req,
  output logic        Tick,
  output logic        Cpu_En,
  output logic [1:0]  Mode,
  output logic        Halted,
  output logic [15:0] Step_Cnt
);

  localparam int DB_W = $clog2(DB_CNT + 1);
  localparam logic [31:0]     DIV_LAST = 32'(TICK_N - 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CNT - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     div_cnt;
  logic            run_s1;
  logic            run_s;
  logic            btn_s1;
  logic            btn_s;
  logic            db_lvl;
  logic [DB_W-1:0] db_cnt;
  logic            step_p;
  logic            run_ok;
  logic            cpu_en_nxt;

  assign Mode = state;

  always_ff @(posedge Clk_xi) begin
    if (Rst_xi) begin
      div_cnt <= '0;
      Tick    <= 1'b0;
    end else begin
      Tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 32'd1;
    end
  end

  always_ff @(posedge Clk_xi) begin
    if (Rst_xi) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      run_s1 <= Run_Sw;
      run_s  <= run_s1;
      btn_s1 <= Step_Btn;
      btn_s  <= btn_s1;
    end
  end

  // Button must disagree with the accepted level for DB_CNT consecutive Ticks;
  // step_p fires only on an accepted press (0->1), one cycle after acceptance.
  always_ff @(posedge Clk_xi) begin
    if (Rst_xi) begin
      db_lvl <= 1'b0;
      db_cnt <= '0;
      step_p <= 1'b0;
    end else begin
      step_p <= 1'b0;
      if (Tick) begin
        if (btn_s == db_lvl) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_lvl <= btn_s;
          db_cnt <= '0;
          step_p <= btn_s;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end
  end

  // Halt sticks while the run switch stays on, so RUN needs an off/on cycle.
  always_ff @(posedge Clk_xi) begin
    if (Rst_xi) begin
      Halted <= 1'b0;
    end else if (Halt_Req) begin
      Halted <= 1'b1;
    end else if (!run_s) begin
      Halted <= 1'b0;
    end
  end

  assign run_ok = run_s && !Halted && !Halt_Req;

  always_comb begin
    state_nxt  = state;
    cpu_en_nxt = 1'b0;
    case (state)
      ST_HALT: begin
        if (run_ok) begin
          state_nxt = ST_RUN;
        end else if (step_p) begin
          state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        cpu_en_nxt = Tick && !Halt_Req && run_s;
        if (!run_s || Halt_Req) begin
          state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        cpu_en_nxt = 1'b1;
        state_nxt  = ST_HALT;
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge Clk_xi) begin
    if (Rst_xi) begin
      state    <= ST_HALT;
      Cpu_En   <= 1'b0;
      Step_Cnt <= '0;
    end else begin
      state  <= state_nxt;
      Cpu_En <= cpu_en_nxt;
      if (Cpu_En) begin
        Step_Cnt <= Step_Cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Run/step/halt sequencer for the R/I/J CPU. It replaces free-running toggled divided clocks with single-cycle enables on the system clock. A programmable divider generates a base Tick. The controller then decides which Ticks become CPU step enables (Cpu_En), based on the run switch, a debounced step button and the CPU halt request. All CPU state elements run on Clk_xi and gate on Cpu_En.

Parameters:
TICK_N, 500000, system-clock cycles per Tick period (at least 2); Tick pulses when the divider counter equals TICK_N-1.
DB_CNT, 4, consecutive Ticks a raw button level must differ from the debounced level before it is accepted (at least 1).

Ports:
Clk_xi  input  1  system clock; every register is on its rising edge.
Rst_xi  input  1  synchronous, active-high reset.
Run_Sw  input  1  asynchronous run switch (1 = run).
Step_Btn  input  1  asynchronous raw single-step push-button.
Halt_Req  input  1  synchronous halt request from CPU decode (halt instruction).
Tick  output  1  one-cycle pulse, period TICK_N clocks; also used by display scan.
Cpu_En  output  1  one-cycle CPU step enable.
Mode  output  2  current state: 00 HALT, 01 RUN, 10 STEP.
Halted  output  1  halt latch.
Step_Cnt  output  16  count of Cpu_En pulses; wraps from FFFF to 0000.

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-RUN or mid-debounce):
  - divider counter, debounce counter, both synchronizers, debounced level and all outputs go to 0.
  - Mode = HALT.
- Divider:
  - 32-bit counter runs 0..TICK_N-1, then wraps to 0.
  - Tick is registered: it is 1 in the cycle after the counter equals TICK_N-1.
  - First Tick is high at cycle TICK_N after reset release (cycle 1 = first edge with Rst_xi low).
- Synchronizers: Run_Sw and Step_Btn each pass through 2 flops (run_s, btn_s).
- Debounce (evaluated only on cycles where Tick = 1):
  - If btn_s equals the debounced level, clear the debounce counter.
  - Otherwise increment it. When it reaches DB_CNT, load btn_s into the debounced level and clear the counter.
  - A 0→1 change of the debounced level produces step_p, a one-cycle internal pulse.
- Halt latch:
  - Set whenever Halt_Req = 1, in any state.
  - Cleared when run_s = 0 and Halt_Req = 0.
  - Output on Halted.
- State machine (Mode is registered):
  - HALT → RUN when run_s = 1, Halted = 0 and Halt_Req = 0.
  - HALT → STEP when step_p = 1 and the RUN condition is false. If both conditions hold, RUN wins and the step is dropped.
  - STEP → HALT unconditionally after one cycle.
  - RUN → HALT when run_s = 0 or Halt_Req = 1.
  - step_p is ignored in RUN and STEP.
- Cpu_En (registered):
  - Set to 1 the cycle after Mode = RUN with Tick = 1, Halt_Req = 0 and run_s = 1.
  - Set to 1 the cycle after Mode = STEP.
  - 0 otherwise.
  - Halt_Req in the same cycle as a RUN Tick suppresses that enable.
- Stepping is allowed while Halted = 1, for debug past a halt. Re-entering RUN requires Run_Sw to go off and then on again.
- Step_Cnt increments by 1 on every cycle with Cpu_En = 1, modulo 2^16.
- Latency: Run_Sw rising to Mode = RUN is 3 edges (2 synchronizer edges + 1 state edge).

Test Plan:
Use TICK_N=4 and DB_CNT=2 for all scenarios.
1. Reset, then hold all inputs at 0 for 20 cycles → Tick is high at cycles 4, 8, 12, 16, 20; Cpu_En, Mode, Halted and Step_Cnt stay 0.
2. Run_Sw=1 from cycle 5 → Mode=01 from cycle 8; Cpu_En goes high one cycle after each subsequent Tick; Step_Cnt = 3 after 3 Ticks.
3. In RUN, assert Halt_Req for one cycle, coincident with Tick → no Cpu_En for that Tick; Mode=00 and Halted=1 the next cycle. Run_Sw stays 1 → no RUN re-entry. Then Run_Sw 0→1 → RUN resumes after 3 edges.
4. In HALT, press Step_Btn with 1-cycle glitches, then hold it stable for 3 Ticks → glitches produce no step. The stable press gives exactly one Cpu_En and Mode=10 for one cycle; Step_Cnt increments by 1. Release and re-press gives a second step.
5. Preload Step_Cnt to FFFF via 65535 steps (or force), then one more step → Step_Cnt = 0000.
6. Assert Rst_xi for 1 cycle mid-RUN and mid-debounce → all outputs are 0 and Mode=00 on the next edge; the next Tick arrives exactly TICK_N cycles after reset release.
